// File: rtl/regfile_wb_ctrl_if.sv
// rtl/regfile_wb_ctrl_if.sv - producer handshakes and register-file write port of the write-back controller
interface regfile_wb_ctrl_if #(
  parameter int DW     = 32,
  parameter int AW     = 4,
  parameter int QDEPTH = 4
);
  localparam int CW = $clog2(QDEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_data;
  logic          alu_ready;
  logic          mem_valid;
  logic [AW-1:0] mem_rd;
  logic [DW-1:0] mem_data;
  logic          mem_ready;
  logic [AW-1:0] wp;
  logic          we;
  logic [DW-1:0] din;
  logic [CW-1:0] q_count;

  modport master (
    output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    input  alu_ready, mem_ready, wp, we, din, q_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data,
    output alu_ready, mem_ready, wp, we, din, q_count
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - ALU/load arbiter onto the register-file write port with load FIFO
// Optional 1-cycle load bypass on an idle, empty controller: WB_LOAD_BYPASS_EN.
module regfile_wb_ctrl #(
  parameter int DW         = 32,
  parameter int AW         = 4,
  parameter int QDEPTH     = 4,
  parameter int STARVE_MAX = 3
) (
  input logic              clk,
  input logic              rst,
  regfile_wb_ctrl_if.slave bus
);
  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] C_FULL = CW'(QDEPTH);
  localparam logic [SW-1:0] C_SMAX = SW'(STARVE_MAX);

  logic [AW-1:0] r_q_rd   [QDEPTH];
  logic [DW-1:0] r_q_data [QDEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [SW-1:0] r_starve;
  logic          r_we;
  logic [AW-1:0] r_wp;
  logic [DW-1:0] r_din;

  logic          w_empty;
  logic          w_force;
  logic          w_alu_grant;
  logic          w_fifo_grant;
  logic          w_bypass;
  logic          w_enq;
  logic          w_sel_valid;
  logic [AW-1:0] w_sel_rd;
  logic [DW-1:0] w_sel_data;

  assign w_empty      = (r_count == '0);
  assign w_force      = !w_empty && (r_starve == C_SMAX);
  assign w_alu_grant  = bus.alu_valid && !w_force;
  assign w_fifo_grant = !w_alu_grant && !w_empty;
`ifdef WB_LOAD_BYPASS_EN
  assign w_bypass     = w_empty && !bus.alu_valid && bus.mem_valid;
`else
  assign w_bypass     = 1'b0;
`endif
  // A bypassed load skips the FIFO entirely, so it must not also be enqueued.
  assign w_enq        = bus.mem_valid && bus.mem_ready && !w_bypass;

  assign bus.alu_ready = !w_force;
  assign bus.mem_ready = (r_count != C_FULL);
  assign bus.we        = r_we;
  assign bus.wp        = r_wp;
  assign bus.din       = r_din;
  assign bus.q_count   = r_count;

  always_comb begin
    w_sel_valid = w_fifo_grant;
    w_sel_rd    = r_q_rd[r_rptr];
    w_sel_data  = r_q_data[r_rptr];
    if (w_alu_grant) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = bus.alu_rd;
      w_sel_data  = bus.alu_data;
    end else if (w_bypass) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = bus.mem_rd;
      w_sel_data  = bus.mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_wp     <= '0;
      r_din    <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_starve <= '0;
    end else begin
      // r0 writes are consumed but never reach the port; wp/din keep the last real write.
      r_we <= w_sel_valid && (w_sel_rd != '0);
      if (w_sel_valid && (w_sel_rd != '0)) begin
        r_wp  <= w_sel_rd;
        r_din <= w_sel_data;
      end
      if (w_enq) r_wptr <= r_wptr + PW'(1);
      if (w_fifo_grant) r_rptr <= r_rptr + PW'(1);
      case ({w_enq, w_fifo_grant})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_empty || w_fifo_grant) r_starve <= '0;
      else if (w_alu_grant && (r_starve != C_SMAX)) r_starve <= r_starve + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq && !rst) begin
      r_q_rd[r_wptr]   <= bus.mem_rd;
      r_q_data[r_wptr] <= bus.mem_data;
    end
  end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-side controller for the 16x32 register file.
- Merges two result producers, the ALU and the memory load path, into the single register-file write port (wp/we/din).
- Load results are buffered in a small FIFO. The ALU has priority, and an anti-starvation counter bounds how long loads can wait.
- All write-port outputs are registered. Writes to r0 are accepted and discarded.

Parameters:
- DW, 32: data width of din and producer data.
- AW, 4: register-number width (16 registers).
- QDEPTH, 4: load FIFO depth; power of 2, at least 2.
- STARVE_MAX, 3: number of consecutive ALU wins with a non-empty FIFO before the FIFO is forced a grant.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- alu_valid  in  1  ALU result valid
- alu_rd  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU result accepted this cycle (combinational)
- mem_valid  in  1  load result valid
- mem_rd  in  AW  load destination register
- mem_data  in  DW  load data
- mem_ready  out  1  load FIFO can accept (combinational)
- wp  out  AW  register-file write port number (registered)
- we  out  1  register-file write enable (registered, one-cycle pulse per write)
- din  out  DW  register-file write data (registered)
- q_count  out  clog2(QDEPTH)+1  current load FIFO occupancy

Behaviour:
- Reset: clk and rst are decided as stated: rst is synchronous, active-high, on clock clk. In the cycle rst is sampled high:
  - we=0, wp=0, din=0;
  - FIFO emptied (q_count=0, pointers 0);
  - starve counter cleared to 0.
  - rst overrides any simultaneous handshake, and in-flight data is discarded.
- Handshakes:
  - mem_ready = (q_count != QDEPTH). A load transfer happens when mem_valid && mem_ready.
  - alu_ready = !force, where force = (q_count != 0) && (starve_cnt == STARVE_MAX). An ALU transfer happens when alu_valid && alu_ready.
- Grant, evaluated each cycle:
  - If alu_valid && !force: ALU granted.
  - Else if q_count != 0: FIFO head granted and dequeued.
  - Else: no grant.
- Output update at the next clk edge:
  - Granted entry with rd != 0: we=1, wp=rd, din=data.
  - Granted entry with rd == 0: entry is consumed, but we=0.
  - No grant: we=0; wp/din hold their previous values.
- Latency:
  - ALU: 1 cycle from transfer to we.
  - Load: at least 2 cycles (enqueue edge, then dequeue and write edge).
- Starve counter:
  - Increments when the ALU is granted and q_count != 0.
  - Clears to 0 when the FIFO is granted or q_count == 0.
  - Saturates at STARVE_MAX.
- FIFO occupancy:
  - Enqueue and dequeue in the same cycle: q_count unchanged, ordering preserved.
  - Full FIFO with a simultaneous dequeue: mem_ready stays 0 that cycle (no pass-through on full).
- Load ordering: loads are written strictly in arrival order. No ordering is guaranteed between the ALU and load streams; the issue logic guarantees no same-rd hazard.
- Boundaries:
  - Write pointers wrap modulo QDEPTH.
  - q_count never exceeds QDEPTH or underflows.
  - mem_valid held while full must not be lost; the producer holds it until mem_ready.

Optional Feature:
- Macro: WB_LOAD_BYPASS_EN.
- Defined: when q_count==0, alu_valid==0 and mem_valid==1 in the same cycle, the load goes directly to the output registers with 1-cycle latency. The FIFO is not written, q_count stays 0, and mem_ready=1.
- Undefined: every load passes through the FIFO (minimum 2-cycle latency).

Test Plan:
- Reset: assert rst 2 cycles with alu_valid=1 -> we=0, wp=0, din=0, q_count=0, mem_ready=1 after release.
- ALU write: alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle we=1, wp=5, din=0xDEADBEEF; following cycle we=0.
- r0 drop: alu_rd=0, alu_data=0x1234 -> alu_ready=1, we stays 0 for all cycles.
- FIFO fill: 5 loads (rd=1..5, data=0x10..0x14) while ALU continuously valid, STARVE_MAX=3:
  - q_count reaches 4 and mem_ready=0 on the 5th.
  - After 3 ALU writes, alu_ready=0 for one cycle and we writes rd=1, data=0x10.
- Drain order: stop the ALU with 4 loads queued -> four consecutive we pulses with wp=1,2,3,4 and din=0x10..0x13; q_count 4,3,2,1,0.
- Bypass (macro defined): idle, empty FIFO, one load rd=7, data=0xA5A5A5A5 -> we=1, wp=7 on the next edge, q_count stays 0. With the macro undefined -> write one cycle later.
